ltc2630_dac_spi: RTL and testbench
==================================

# ltc2630_dac_spi

Serial write engine for the LTC2630 VCTCXO tuning DAC; sits directly downstream of the reference PLL loop and consumes its 16-bit `dac_value`. Watches the input word, and whenever it differs from the last word written (or after reset) emits one 24-bit SPI frame: write-and-update command, don't-care address, 16-bit MSB-aligned code. Outputs are fully registered and drive the DAC pins directly.

## Interface
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles, legal 1..255; 200 MHz / (2·4) = 25 MHz SCLK.
- `GAP_CYCLES`, 8: minimum `sync_n` high time between frames, in `clk` cycles, legal 1..255.
- `clk`  in  1  sample clock, 200 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `data`  in  16  requested DAC code; sampled only in IDLE.
- `sclk`  out  1  SPI clock; idles low; DAC samples `mosi` on rising edge.
- `mosi`  out  1  SPI data, MSB first.
- `sync_n`  out  1  frame select, active low.
- `busy`  out  1  high from frame launch until GAP ends.
- `done`  out  1  one-cycle pulse when `sync_n` returns high.

## Operation
- Frame word, bits 23..0:
  - `{cmd[3:0], 4'b0000, code[15:0]}`.
  - `cmd` = 4'b0011 (write and update).
  - `code` = captured `data`.
- Registers:
  - `last_sent[15:0]`.
  - `init_pending`: set by reset.
  - 24-bit shift register.
  - 8-bit half-period counter.
  - 5-bit bit counter.
- State machine IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - `sclk`=0, `sync_n`=1, `mosi`=0, `busy`=0.
  - Launch condition: `init_pending` or `data != last_sent`.
  - On launch: load shift register, `last_sent<=data`, clear `init_pending`, `sync_n<=0`, `mosi<=word[23]`, `busy<=1`, go SETUP.
- SETUP: hold `sclk` low for CLK_DIV cycles, then `sclk<=1`, go SHIFT.
- SHIFT:
  - `sclk` toggles every CLK_DIV cycles.
  - On each falling edge except the last, shift and present the next bit on `mosi`.
  - After the 24th high phase, `sclk<=0` and go HOLD.
- HOLD: `sync_n` stays low for CLK_DIV cycles, then `sync_n<=1`, `done<=1` for one cycle, go GAP.
- GAP: wait GAP_CYCLES, then go IDLE. A pending change may launch on the first IDLE cycle.
- `data` changes during a frame are not captured mid-frame. The value present in IDLE wins, so intermediate values are dropped.
- If `data` changes and reverts to `last_sent` before IDLE, no frame is sent.
- Reset asserted mid-frame:
  - Immediately forces `sync_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, state IDLE.
  - Sets `init_pending`, so the DAC is rewritten after release.
- Reset values: `sync_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `last_sent`=0, `init_pending`=1.

## Timing
- Launch latency: `sync_n` falls 1 cycle after the IDLE cycle in which the condition is true.
- First `sclk` rise: CLK_DIV cycles after `sync_n` falls.
- `mosi` setup and hold around each `sclk` rise: CLK_DIV cycles each.
- `sync_n` low time: 50·CLK_DIV cycles (200 at default).
- Frame-to-frame period (launch to launch, back-to-back changes): 50·CLK_DIV + GAP_CYCLES + 1 cycles (209 at default).
- Exactly 24 `sclk` rising edges per frame; `sclk` is low when `sync_n` toggles.
- All outputs come straight from flops; there is no combinational path from `data` to any pin.

## Configuration
- `LTC2630_DAC_SPI_INTREF_EN` defined:
  - The first frame after every reset release is `{4'b0110, 4'b0000, 16'h0000}` (select internal reference).
  - It is followed by the normal data frame with `cmd`=4'b0011 after GAP.
  - `busy` stays high across both frames; `done` pulses once per frame.
- Undefined: no reference-select frame is sent. The reset-triggered frame is the data frame only, and the DAC uses its power-on reference setting.

## Test plan
- Release reset with `data`=16'h7FFF held → one frame; 24 bits decoded on `sclk` rise = 24'h307FFF; `sync_n` low 200 cycles; `done` pulses once; no further frames.
- `data` 16'h7FFF→16'h8123 while idle → `sync_n` falls 1 cycle later; decoded 24'h308123.
- Change `data` to 16'h0001, then 16'h0002, then 16'hFFFF within one frame → after GAP exactly one more frame, 24'h30FFFF.
- Change `data` from 16'h1234 to 16'h5555 and back to 16'h1234 during a frame of 16'h1234 → no second frame; `busy` low after GAP.
- Assert `resetn` at bit 10 of a frame → same cycle `sync_n`=1, `sclk`=0; after release a full frame with current `data` is sent.
- With `LTC2630_DAC_SPI_INTREF_EN`, `data`=16'hA000 → frames 24'h600000 then 24'h30A000; launch-to-launch 209 cycles; `done` pulses twice.

Source files
------------

// File: rtl/ltc2630_dac_spi_if.sv
// Pin-level bundle between the LTC2630 write engine and the DAC/controller side.
// master = the write engine (drives the SPI pins), slave = the code source / DAC side.
interface ltc2630_dac_spi_if;
  logic [15:0] data;
  logic        sclk;
  logic        mosi;
  logic        sync_n;
  logic        busy;
  logic        done;

  modport master (input data, output sclk, mosi, sync_n, busy, done);
  modport slave  (output data, input sclk, mosi, sync_n, busy, done);
endinterface

// File: rtl/ltc2630_dac_spi.sv
// LTC2630 SPI write engine: sends one 24-bit write-and-update frame whenever the code changes.
// Optional LTC2630_DAC_SPI_INTREF_EN: prepend an internal-reference select frame after each reset.
module ltc2630_dac_spi #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic clk,
  input  logic resetn,
  ltc2630_dac_spi_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] CMD_WRITE = 4'b0011;

  state_t      state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [15:0] last_sent_q, last_sent_d;
  logic        init_pending_q, init_pending_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        sync_n_q, sync_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [23:0] launch_word;
`ifdef LTC2630_DAC_SPI_INTREF_EN
  localparam logic [3:0] CMD_REF = 4'b0110;
  logic        ref_pending_q, ref_pending_d;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      last_sent_q    <= '0;
      init_pending_q <= 1'b1;
      div_q          <= '0;
      bit_q          <= '0;
      sclk_q         <= 1'b0;
      mosi_q         <= 1'b0;
      sync_n_q       <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef LTC2630_DAC_SPI_INTREF_EN
      ref_pending_q  <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      last_sent_q    <= last_sent_d;
      init_pending_q <= init_pending_d;
      div_q          <= div_d;
      bit_q          <= bit_d;
      sclk_q         <= sclk_d;
      mosi_q         <= mosi_d;
      sync_n_q       <= sync_n_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef LTC2630_DAC_SPI_INTREF_EN
      ref_pending_q  <= ref_pending_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    last_sent_d    = last_sent_q;
    init_pending_d = init_pending_q;
    div_d          = div_q;
    bit_d          = bit_q;
    sclk_d         = sclk_q;
    mosi_d         = mosi_q;
    sync_n_d       = sync_n_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    launch_word    = {CMD_WRITE, 4'b0000, bus.data};
`ifdef LTC2630_DAC_SPI_INTREF_EN
    ref_pending_d  = ref_pending_q;
`endif

    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (init_pending_q || (bus.data != last_sent_q)) begin
`ifdef LTC2630_DAC_SPI_INTREF_EN
          // Reference frame leaves init_pending set so the data frame follows it.
          if (ref_pending_q) begin
            launch_word   = {CMD_REF, 4'b0000, 16'h0000};
            ref_pending_d = 1'b0;
          end else begin
            last_sent_d    = bus.data;
            init_pending_d = 1'b0;
          end
`else
          last_sent_d    = bus.data;
          init_pending_d = 1'b0;
`endif
          shift_d  = launch_word;
          mosi_d   = launch_word[23];
          sync_n_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
            if (bit_q != 5'd23) begin
              shift_d = {shift_q[22:0], 1'b0};
              mosi_d  = shift_q[22];
            end
          end else if (bit_q == 5'd24) begin
            // Trailing low phase done; keep mosi stable, then hold sync_n.
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          sync_n_d = 1'b1;
          mosi_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = GAP;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          // busy stays up only when a follow-on frame is already owed (reference then data).
          busy_d  = init_pending_q;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sclk   = sclk_q;
  assign bus.mosi   = mosi_q;
  assign bus.sync_n = sync_n_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_ltc2630_dac_spi.sv
// Directed bench for ltc2630_dac_spi: a frame monitor decodes SPI words and checks them
// against a queue of expected frames pushed by the stimulus sequence.
module tb_ltc2630_dac_spi;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int PERIOD  = 50 * CLK_DIV + GAP + 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ltc2630_dac_spi_if bus ();

  ltc2630_dac_spi #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];
  int          cyc = 0, frames_done = 0, done_cnt = 0, rises = 0;
  int          fall_last = 0, fall_prev = 0;
  int          nf = 0;
  bit          in_frame = 0;
  logic [23:0] word = '0;
  logic        prev_sclk = 1'b0, prev_sync_n = 1'b1;
  logic [23:0] exp_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frames_done < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (frames_done < n) begin
      checks++;
      errors++;
      $error("FAIL wait_frames: observed=%0d expected=%0d", frames_done, n);
    end
  endtask

  // Frame monitor, sampling on the falling clk edge away from DUT updates.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      in_frame    = 0;
      rises       = 0;
      prev_sclk   = 1'b0;
      prev_sync_n = 1'b1;
    end else begin
      if (!in_frame && prev_sync_n && !bus.sync_n) begin
        in_frame  = 1;
        word      = '0;
        rises     = 0;
        fall_prev = fall_last;
        fall_last = cyc;
        chk("sclk_at_sync_fall", bus.sclk, 1'b0);
      end
      if (in_frame && bus.sclk && !prev_sclk) begin
        word = {word[22:0], bus.mosi};
        rises++;
      end
      if (in_frame && bus.sync_n) begin
        in_frame = 0;
        frames_done++;
        chk("sclk_rises", rises, 24);
        chk("sync_n_low_time", cyc - fall_last, 50 * CLK_DIV);
        chk("sclk_at_sync_rise", bus.sclk, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_frame: observed=%06h expected=none", word);
        end else begin
          exp_word = exp_q.pop_front();
          chk("frame_word", word, exp_word);
        end
      end
      if (bus.done) done_cnt++;
      prev_sclk   = bus.sclk;
      prev_sync_n = bus.sync_n;
    end
  end

  initial begin
    int k;
    // Reset with 7FFF applied
    bus.data = 16'h7FFF;
    resetn   = 1'b0;
    idle(3);
    chk("reset_sync_n", bus.sync_n, 1'b1);
    chk("reset_sclk",   bus.sclk,   1'b0);
    chk("reset_mosi",   bus.mosi,   1'b0);
    chk("reset_busy",   bus.busy,   1'b0);
    chk("reset_done",   bus.done,   1'b0);
`ifdef LTC2630_DAC_SPI_INTREF_EN
    exp_q.push_back(24'h600000);
    nf++;
`endif
    exp_q.push_back(24'h307FFF);
    nf++;
    resetn = 1'b1;
    wait_frames(nf);
`ifdef LTC2630_DAC_SPI_INTREF_EN
    chk("ref_to_data_period", fall_last - fall_prev, PERIOD);
`endif
    idle(100);
    chk("frames_after_reset", frames_done, nf);
    chk("done_after_reset",   done_cnt,    nf);
    chk("busy_idle_1",        bus.busy,    1'b0);

    // Idle change: launch latency
    chk("pre_launch_sync_n", bus.sync_n, 1'b1);
    bus.data = 16'h8123;
    exp_q.push_back(24'h308123);
    nf++;
    @(negedge clk);
    chk("launch_latency_sync_n", bus.sync_n, 1'b0);
    chk("launch_busy",           bus.busy,   1'b1);

    // Several changes within one frame: only the last one is sent
    idle(30);
    bus.data = 16'h0001;
    idle(30);
    bus.data = 16'h0002;
    idle(30);
    bus.data = 16'hFFFF;
    exp_q.push_back(24'h30FFFF);
    nf++;
    wait_frames(nf);
    chk("back_to_back_period", fall_last - fall_prev, PERIOD);
    idle(300);
    chk("frames_after_coalesce", frames_done, nf);

    // Change and revert during a frame: no second frame
    bus.data = 16'h1234;
    exp_q.push_back(24'h301234);
    nf++;
    idle(20);
    bus.data = 16'h5555;
    idle(50);
    bus.data = 16'h1234;
    wait_frames(nf);
    idle(GAP + 20);
    chk("busy_after_revert", bus.busy, 1'b0);
    idle(250);
    chk("frames_after_revert", frames_done, nf);
    chk("done_after_revert",   done_cnt,    nf);

    // Reset at bit 10 of a frame
    bus.data = 16'hABCD;
    exp_q.push_back(24'h30ABCD);
    k = 0;
    while (!(in_frame && rises >= 10) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("reached_bit10", rises >= 10, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("midreset_sync_n", bus.sync_n, 1'b1);
    chk("midreset_sclk",   bus.sclk,   1'b0);
    chk("midreset_mosi",   bus.mosi,   1'b0);
    chk("midreset_busy",   bus.busy,   1'b0);
    void'(exp_q.pop_front());
    idle(3);
`ifdef LTC2630_DAC_SPI_INTREF_EN
    exp_q.push_back(24'h600000);
    nf++;
`endif
    exp_q.push_back(24'h30ABCD);
    nf++;
    resetn = 1'b1;
    wait_frames(nf);
    idle(300);
    chk("frames_after_midreset", frames_done, nf);
    chk("done_after_midreset",   done_cnt,    nf);
    chk("queue_drained",         exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
